// File: rtl/constraint_sample_sequencer_if.sv
// constraint_sample_sequencer_if: host, checker and sample-consumer signals of the sequencer.
interface constraint_sample_sequencer_if #(
  parameter int VEC_W = 256
);
  logic             start_i;
  logic [15:0]      req_n_i;
  logic             abort_i;
  logic             seed_load_i;
  logic [31:0]      seed_i;
  logic [VEC_W-1:0] cand_o;
  logic             cand_valid_o;
  logic             chk_x_i;
  logic [VEC_W-1:0] sample_o;
  logic             sample_valid_o;
  logic             sample_ready_i;
  logic             busy_o;
  logic             done_o;
  logic             fail_o;
  logic [15:0]      try_count_o;
  modport master (
    output start_i, req_n_i, abort_i, seed_load_i, seed_i, chk_x_i, sample_ready_i,
    input  cand_o, cand_valid_o, sample_o, sample_valid_o, busy_o, done_o, fail_o, try_count_o
  );
  modport slave (
    input  start_i, req_n_i, abort_i, seed_load_i, seed_i, chk_x_i, sample_ready_i,
    output cand_o, cand_valid_o, sample_o, sample_valid_o, busy_o, done_o, fail_o, try_count_o
  );
endinterface

// File: rtl/constraint_sample_sequencer.sv
// constraint_sample_sequencer: fills LFSR candidates, waits on the checker and emits accepted samples.
module constraint_sample_sequencer #(
  parameter int          VEC_W     = 256,
  parameter int          CHECK_LAT = 0,
  parameter int          MAX_TRIES = 1024,
  parameter logic [31:0] SEED      = 32'h0000_0001
) (
  input logic clk,
  input logic rst,
  constraint_sample_sequencer_if.slave bus
);
  localparam int WORDS = (VEC_W + 31) / 32;
  localparam int WW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int LW = CHECK_LAT > 0 ? $clog2(CHECK_LAT + 1) : 1;
  typedef enum logic [2:0] {IDLE, FILL, CHECK, OUT, FAIL} state_t;
  state_t           state_q;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [VEC_W-1:0] cand_q, cand_d, sample_q;
  logic [15:0]      rem_q, try_q, try_d;
  logic [WW-1:0]    word_q;
  logic [LW-1:0]    lat_q;
  logic             cvalid_q, svalid_q, busy_q, done_q, fail_q;
  assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
  // Older words shift up so the first generated word ends in the top bits.
  assign cand_d = VEC_W'({cand_q, lfsr_d});
  assign try_d  = try_q + 16'(try_q != 16'hffff);
  assign bus.cand_o         = cand_q;
  assign bus.cand_valid_o   = cvalid_q;
  assign bus.sample_o       = sample_q;
  assign bus.sample_valid_o = svalid_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.fail_o         = fail_q;
  assign bus.try_count_o    = try_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      cand_q   <= '0;
      sample_q <= '0;
      rem_q    <= '0;
      try_q    <= '0;
      word_q   <= '0;
      lat_q    <= '0;
      cvalid_q <= 1'b0;
      svalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort_i) begin
        state_q  <= IDLE;
        cvalid_q <= 1'b0;
        svalid_q <= 1'b0;
        busy_q   <= 1'b0;
        fail_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE, FAIL: begin
            if (bus.seed_load_i) lfsr_q <= bus.seed_i != 32'h0 ? bus.seed_i : SEED;
            if (bus.start_i) begin
              fail_q <= 1'b0;
              if (bus.req_n_i == 16'h0) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else begin
                state_q <= FILL;
                busy_q  <= 1'b1;
                rem_q   <= bus.req_n_i;
                try_q   <= '0;
                word_q  <= '0;
              end
            end
          end
          FILL: begin
            lfsr_q <= lfsr_d;
            cand_q <= cand_d;
            word_q <= word_q + WW'(1);
            if (word_q == WW'(WORDS - 1)) begin
              state_q  <= CHECK;
              cvalid_q <= 1'b1;
              lat_q    <= '0;
            end
          end
          CHECK: begin
            lat_q <= lat_q + LW'(1);
            if (lat_q == LW'(CHECK_LAT)) begin
              cvalid_q <= 1'b0;
              try_q    <= try_d;
              word_q   <= '0;
              if (bus.chk_x_i) begin
                state_q  <= OUT;
                sample_q <= cand_q;
                svalid_q <= 1'b1;
              end else if (try_d == 16'(MAX_TRIES)) begin
                state_q <= FAIL;
                busy_q  <= 1'b0;
                fail_q  <= 1'b1;
              end else begin
                state_q <= FILL;
              end
            end
          end
          OUT: begin
            if (bus.sample_ready_i) begin
              svalid_q <= 1'b0;
              rem_q    <= rem_q - 16'd1;
              word_q   <= '0;
              if (rem_q == 16'd1) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= FILL;
                try_q   <= '0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_constraint_sample_sequencer.sv
// tb_constraint_sample_sequencer: directed checks on a 64-bit/latency-1 and a 32-bit/4-try sequencer.
module tb_constraint_sample_sequencer;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic b_every3 = 1'b0;
  int bcnt = 0;
  always #5 clk = ~clk;
  constraint_sample_sequencer_if #(.VEC_W(64)) a();
  constraint_sample_sequencer_if #(.VEC_W(32)) b();
  constraint_sample_sequencer #(.VEC_W(64), .CHECK_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(a));
  constraint_sample_sequencer #(.VEC_W(32), .CHECK_LAT(0), .MAX_TRIES(4)) dut_b (.clk(clk), .rst(rst), .bus(b));
  always @(posedge clk) bcnt <= !b_every3 ? 0 : bcnt + (b.cand_valid_o ? 1 : 0);
  assign b.chk_x_i = b_every3 && (bcnt % 3 == 2);
  function automatic logic [31:0] lf(input logic [31:0] s, input int n);
    logic [31:0] v = s;
    for (int i = 0; i < n; i++) v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    return v;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    {a.start_i, a.abort_i, a.seed_load_i, a.chk_x_i, a.sample_ready_i} = '0;
    {b.start_i, b.abort_i, b.seed_load_i, b.sample_ready_i} = '0;
    a.req_n_i = 16'd0; a.seed_i = 32'd0; b.req_n_i = 16'd0; b.seed_i = 32'd0;
    step(2);
    chk("rst_cand", a.cand_o, 64'h0);
    chk("rst_sample", a.sample_o, 64'h0);
    chk("rst_flags", {a.cand_valid_o, a.sample_valid_o, a.busy_o, a.done_o, a.fail_o}, 5'b0);
    chk("rst_try", a.try_count_o, 16'd0);
    rst = 1'b0;
    step(1);
    a.seed_load_i = 1'b1; a.seed_i = 32'd1; a.start_i = 1'b1; a.req_n_i = 16'd3;
    a.chk_x_i = 1'b1; a.sample_ready_i = 1'b1;
    step(1);
    a.start_i = 1'b0; a.seed_load_i = 1'b0;
    chk("t1_busy_c1", a.busy_o, 1'b1);
    chk("t1_cvalid_c1", a.cand_valid_o, 1'b0);
    step(3);
    chk("t1_cvalid_c4", a.cand_valid_o, 1'b1);
    chk("t1_svalid_c4", a.sample_valid_o, 1'b0);
    step(1);
    chk("t1_svalid_c5", a.sample_valid_o, 1'b1);
    chk("t1_hi_word", a.sample_o[63:32], 32'h8020_0003);
    chk("t1_sample1", a.sample_o, {lf(1, 1), lf(1, 2)});
    chk("t1_try1", a.try_count_o, 16'd1);
    step(1);
    chk("t1_svalid_c6", a.sample_valid_o, 1'b0);
    step(4);
    chk("t1_sample2", a.sample_o, {32'h6018_0001, 32'hB02C_0003});
    chk("t1_try2", a.try_count_o, 16'd1);
    step(5);
    chk("t1_sample3", a.sample_o, {lf(1, 5), lf(1, 6)});
    chk("t1_try3", a.try_count_o, 16'd1);
    chk("t1_nodone_c15", a.done_o, 1'b0);
    step(1);
    chk("t1_done", {a.done_o, a.busy_o}, 2'b10);
    step(1);
    chk("t1_done_once", a.done_o, 1'b0);
    b.sample_ready_i = 1'b1; b.seed_load_i = 1'b1; b.seed_i = 32'h0000_1234;
    step(1);
    b.seed_i = 32'h0;
    step(1);
    b.seed_load_i = 1'b0; b.start_i = 1'b1; b.req_n_i = 16'd1;
    step(1);
    b.start_i = 1'b0;
    step(1);
    chk("t2_seed0_cand", b.cand_o, 32'h8020_0003);
    step(6);
    chk("t2_nofail_c8", b.fail_o, 1'b0);
    step(1);
    chk("t2_fail_c9", b.fail_o, 1'b1);
    chk("t2_try_max", b.try_count_o, 16'd4);
    chk("t2_fail_flags", {b.busy_o, b.sample_valid_o}, 2'b00);
    b_every3 = 1'b1; b.sample_ready_i = 1'b0; b.start_i = 1'b1; b.req_n_i = 16'd2;
    step(1);
    b.start_i = 1'b0;
    chk("t3_fail_clr", {b.fail_o, b.busy_o}, 2'b01);
    chk("t3_try_clr", b.try_count_o, 16'd0);
    step(6);
    chk("t3_svalid", b.sample_valid_o, 1'b1);
    chk("t3_sample1", b.sample_o, 32'hB62D_8003);
    chk("t3_try1", b.try_count_o, 16'd3);
    step(9);
    chk("t4_hold_valid", b.sample_valid_o, 1'b1);
    chk("t4_hold_sample", b.sample_o, lf(1, 7));
    chk("t4_hold_cand", b.cand_o, lf(1, 7));
    step(1);
    chk("t4_still_valid", b.sample_valid_o, 1'b1);
    b.sample_ready_i = 1'b1;
    step(1);
    chk("t4_handshake", {b.sample_valid_o, b.busy_o}, 2'b01);
    step(6);
    chk("t3_sample2", b.sample_o, lf(1, 10));
    chk("t3_try2", b.try_count_o, 16'd3);
    step(1);
    chk("t3_done", {b.done_o, b.busy_o}, 2'b10);
    b_every3 = 1'b0;
    a.sample_ready_i = 1'b0; a.start_i = 1'b1; a.req_n_i = 16'd2;
    step(1);
    a.start_i = 1'b0;
    step(2);
    chk("t5_in_check", a.cand_valid_o, 1'b1);
    a.abort_i = 1'b1;
    step(1);
    a.abort_i = 1'b0;
    chk("t5_abort_chk", {a.busy_o, a.cand_valid_o, a.sample_valid_o, a.done_o}, 4'b0);
    a.start_i = 1'b1;
    step(1);
    a.start_i = 1'b0;
    step(4);
    chk("t5_out_sample", a.sample_o, {lf(1, 9), lf(1, 10)});
    a.abort_i = 1'b1;
    step(1);
    a.abort_i = 1'b0;
    chk("t5_abort_out", {a.busy_o, a.sample_valid_o, a.done_o}, 3'b0);
    chk("t5_try_hold", a.try_count_o, 16'd1);
    step(1);
    chk("t5_no_done", a.done_o, 1'b0);
    a.start_i = 1'b1; a.req_n_i = 16'd0;
    step(1);
    a.start_i = 1'b0;
    chk("t6_req0_done", {a.done_o, a.busy_o}, 2'b10);
    step(1);
    chk("t6_req0_after", {a.done_o, a.busy_o}, 2'b00);
    a.seed_load_i = 1'b1; a.seed_i = 32'd2; a.start_i = 1'b1; a.req_n_i = 16'd1; a.sample_ready_i = 1'b1;
    step(1);
    a.seed_load_i = 1'b0; a.start_i = 1'b0;
    step(4);
    chk("t7_seed_start", a.sample_o, {32'h0000_0001, 32'h8020_0003});
    step(1);
    chk("t7_done", a.done_o, 1'b1);
    a.start_i = 1'b1; a.req_n_i = 16'd1;
    step(1);
    a.start_i = 1'b0;
    step(1);
    rst = 1'b1;
    #1;
    chk("t8_rst_flags", {a.busy_o, a.done_o, a.cand_valid_o}, 3'b0);
    chk("t8_rst_cand", a.cand_o, 64'h0);
    chk("t8_rst_sample", a.sample_o, 64'h0);
    chk("t8_rst_try", a.try_count_o, 16'd0);
    step(1);
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/constraint_sample_sequencer.md
# constraint_sample_sequencer

Sequencer that drives a generated combinational constraint checker (packed candidate vector in, single satisfied bit `x` out) to produce constrained-random samples. It fills a candidate vector from a 32-bit LFSR, presents it to the checker, waits the checker latency, and then does one of three things: emits the candidate on a valid/ready output, retries with a new candidate, or reports failure after a try budget. It sits between the test-generation host (start/seed/count) and one checker instance, so the checker can run unattended for N samples.

## Interface
- `VEC_W`, default 256: packed candidate width (sum of checker input widths); must be ≥ 1.
- `CHECK_LAT`, default 0: checker latency in cycles (0 = purely combinational).
- `MAX_TRIES`, default 1024: candidates allowed per sample before failure; must be in 1..65535.
- `SEED`, default 32'h0000_0001: LFSR reset value; also replaces a loaded zero seed; must be nonzero.

Derived: `WORDS = ceil(VEC_W/32)`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  pulse; begins a run (accepted in IDLE or FAIL only).
- `req_n_i`  in  16  number of samples requested; sampled with `start_i`.
- `abort_i`  in  1  return to IDLE from any state.
- `seed_load_i`  in  1  load LFSR from `seed_i` (accepted in IDLE/FAIL only).
- `seed_i`  in  32  seed value.
- `cand_o`  out  VEC_W  candidate to checker.
- `cand_valid_o`  out  1  high while in CHECK.
- `chk_x_i`  in  1  checker satisfied bit.
- `sample_o`  out  VEC_W  accepted candidate.
- `sample_valid_o`  out  1  sample available.
- `sample_ready_i`  in  1  consumer accepts.
- `busy_o`  out  1  state is FILL, CHECK or OUT.
- `done_o`  out  1  one-cycle pulse when a run completes.
- `fail_o`  out  1  high in FAIL.
- `try_count_o`  out  16  candidates tried for the current/last sample.

## Operation
- States: IDLE, FILL, CHECK, OUT, FAIL.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003). Advances exactly once per FILL cycle and never otherwise. State persists across runs. Seed load writes `seed_i`, or `SEED` if `seed_i`==0.
- IDLE/FAIL + `start_i`:
  - `req_n_i`==0: `done_o` pulses next cycle and the state is IDLE.
  - Otherwise: remaining ← `req_n_i`, `try_count_o` ← 0, FILL, `fail_o` cleared.
  - `start_i` and `seed_load_i` together: the seed loads first, and the run uses the new seed.
- FILL, WORDS cycles: each cycle the LFSR advances, then cand ← (cand << 32) | lfsr_next, truncated to VEC_W. The first generated word lands in the most significant position. Exit to CHECK.
- CHECK, CHECK_LAT+1 cycles: `cand_o` is held stable. `chk_x_i` is sampled in the last CHECK cycle, and `try_count_o` increments by 1 (saturating at 65535). Then:
  - x=1: `sample_o` ← cand, go to OUT.
  - x=0 and tries==MAX_TRIES: go to FAIL.
  - Otherwise: go to FILL.
- OUT:
  - `sample_valid_o`=1; `sample_o` is stable until the handshake (`sample_valid_o`&&`sample_ready_i`).
  - On the handshake, remaining decrements. If it reaches 0: IDLE plus `done_o` pulse (same edge). Otherwise: `try_count_o` ← 0, FILL.
- FAIL: `fail_o`=1 and `busy_o`=0. Stays until `start_i` or `abort_i`. `try_count_o` holds MAX_TRIES.
- `abort_i` has priority over every other event. Next state is IDLE, `sample_valid_o` drops, and no `done_o` is produced. The LFSR keeps any advances already made, and `try_count_o` holds its value.
- `start_i` outside IDLE/FAIL is ignored. `seed_load_i` outside IDLE/FAIL is ignored.

## Timing
- Reset values: state IDLE, LFSR=SEED, `cand_o`=0, `sample_o`=0. `cand_valid_o`, `sample_valid_o`, `busy_o`, `done_o`, `fail_o` are all 0. `try_count_o`=0.
- All outputs are registered.
- `start_i` sampled at edge 0 → FILL during cycles 1..WORDS → CHECK during cycles WORDS+1..WORDS+1+CHECK_LAT → first possible `sample_valid_o` in cycle WORDS+CHECK_LAT+2.
- Each retry costs WORDS+CHECK_LAT+1 cycles. After a handshake, the next sample restarts with FILL in the following cycle.
- `chk_x_i` is ignored outside the final CHECK cycle.
- Reset asserted mid-run: immediate return to reset values, with no `done_o`.

## Test plan
- VEC_W=64, CHECK_LAT=1, `seed_i`=1 loaded, `chk_x_i` tied 1, `req_n_i`=3, ready tied 1:
  - `sample_valid_o` first rises in cycle 5.
  - `sample_o[63:32]` = LFSR step 1 from seed 1 = 32'h8020_0003, and `sample_o[31:0]` = step 2.
  - Exactly 3 handshakes, `done_o` on the third, `try_count_o`=1 each time.
- `chk_x_i` tied 0, MAX_TRIES=4, VEC_W=32, CHECK_LAT=0:
  - `fail_o` rises 8 cycles after `start_i`, with `try_count_o`=4 and no `sample_valid_o`.
  - A new `start_i` clears `fail_o`.
- Checker model returns x=1 only on every 3rd candidate, `req_n_i`=2: `try_count_o`=3 at each handshake; the LFSR has advanced 6·WORDS steps in total.
- Backpressure: `sample_ready_i` low for 10 cycles while in OUT. `sample_valid_o` and `sample_o` stay stable, the LFSR does not advance, and the handshake completes on the first ready cycle.
- `abort_i` during CHECK, then during OUT: next cycle IDLE, `busy_o`=0, `sample_valid_o`=0, no `done_o`.
- `seed_load_i` with `seed_i`=0: the LFSR becomes SEED. `start_i` with `req_n_i`=0: `done_o` pulses once and `busy_o` never rises.
